onchip_mem_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the single-port 32-bit × 4096-word on-chip RAM between the Nios II data master (m0) and the camera frame-capture writer (m1). It sits directly in front of the RAM's single Avalon slave port. It serialises accesses to one per clock and steers each one-cycle-latency read return back to the master that issued it.

---
 rtl/onchip_mem_arbiter.sv | 117 +++++++++++
 tb/tb_onchip_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM. Round-robin when ONCHIP_ARB_RR_EN is defined, m0 fixed priority otherwise.
// Latency: grant/mem_* combinational in the request cycle; read return exactly one cycle after accept.
// Backpressure: the losing master sees waitrequest=1 and holds its request; both stall while reset is high.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              wr;
  } mreq_t;

  mreq_t req0, req1, req_sel;
  logic  m0_req, m1_req;
  logic  gnt0, gnt1;
  logic  rd_issue;
  logic  rd_pend;
  logic  rd_owner;   // 0 = m0, 1 = m1

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

`ifdef ONCHIP_ARB_RR_EN
  logic last_grant;  // 0 = m0, 1 = m1

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_grant <= gnt1;
    end
  end
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
`ifdef ONCHIP_ARB_RR_EN
      if (m0_req && m1_req) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
`else
      gnt0 = m0_req;
      gnt1 = m1_req && !m0_req;
`endif
    end
  end

  assign req0    = '{addr: m0_address, be: m0_byteenable, wdata: m0_writedata, wr: m0_write};
  assign req1    = '{addr: m1_address, be: m1_byteenable, wdata: m1_writedata, wr: m1_write};
  assign req_sel = gnt1 ? req1 : req0;

  assign m0_waitrequest = !gnt0;
  assign m1_waitrequest = !gnt1;

  assign mem_address    = req_sel.addr;
  assign mem_byteenable = req_sel.be;
  assign mem_writedata  = req_sel.wdata;
  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 | gnt1) & req_sel.wr;
  assign mem_clken      = 1'b1;

  // write wins over a simultaneous read, so a read+write never produces a return
  assign rd_issue = (gnt0 & m0_read & !m0_write) | (gnt1 & m1_read & !m1_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= rd_issue;
      rd_owner <= gnt1;
    end
  end

  // reset in the return cycle drops the return that was in flight
  assign m0_readdatavalid = rd_pend & !rd_owner & !reset;
  assign m1_readdatavalid = rd_pend &  rd_owner & !reset;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // RAM behind the arbiter: registered read address, unregistered q
  logic [31:0] ram [4096];
  logic [31:0] ram_q;
  assign mem_readdata = ram_q;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[mem_address];
      end
    end
  end

  typedef struct {
    bit          vld;
    bit          rd;
    bit          wr;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } txn_t;

  txn_t        p [2];          // request each master currently presents
  logic [31:0] shadow [4096];  // expected memory contents
  int          prev_gnt;       // master granted most recently
  bit          ret_vld;
  int          ret_owner;
  logic [31:0] ret_data;
  int          cnt_rdv [2];
  logic [31:0] last_rd [2];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic issue(input int m, input bit rd, input bit wr, input logic [11:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
    p[m].vld = 1'b1; p[m].rd = rd; p[m].wr = wr;
    p[m].addr = addr; p[m].be = be; p[m].data = data;
  endtask

  // one clock: drive, check at negedge, advance the model, return 1ns after the next posedge
  task automatic step(input bit rst);
    int g;
    bit nret_vld;
    int nret_owner;
    logic [31:0] nret_data;
    reset = rst;
    m0_read = p[0].vld & p[0].rd;  m0_write = p[0].vld & p[0].wr;
    m0_address = p[0].addr; m0_byteenable = p[0].be; m0_writedata = p[0].data;
    m1_read = p[1].vld & p[1].rd;  m1_write = p[1].vld & p[1].wr;
    m1_address = p[1].addr; m1_byteenable = p[1].be; m1_writedata = p[1].data;
    @(negedge clk);
    if (m0_readdatavalid) begin cnt_rdv[0]++; last_rd[0] = m0_readdata; end
    if (m1_readdatavalid) begin cnt_rdv[1]++; last_rd[1] = m1_readdata; end
    chk("clken", {31'd0, mem_clken}, 32'd1);
    nret_vld = 1'b0; nret_owner = 0; nret_data = '0;
    if (rst) begin
      chk("rst_wait0", {31'd0, m0_waitrequest}, 32'd1);
      chk("rst_wait1", {31'd0, m1_waitrequest}, 32'd1);
      chk("rst_cs", {31'd0, mem_chipselect}, 32'd0);
      chk("rst_wr", {31'd0, mem_write}, 32'd0);
      chk("rst_rdv0", {31'd0, m0_readdatavalid}, 32'd0);
      chk("rst_rdv1", {31'd0, m1_readdatavalid}, 32'd0);
      prev_gnt = 1;
    end else begin
`ifdef ONCHIP_ARB_RR_EN
      if (p[0].vld && p[1].vld) g = 1 - prev_gnt;
`else
      if (p[0].vld && p[1].vld) g = 0;
`endif
      else if (p[0].vld) g = 0;
      else if (p[1].vld) g = 1;
      else g = -1;
      chk("wait0", {31'd0, m0_waitrequest}, {31'd0, g != 0});
      chk("wait1", {31'd0, m1_waitrequest}, {31'd0, g != 1});
      chk("cs", {31'd0, mem_chipselect}, {31'd0, g >= 0});
      chk("rdv0", {31'd0, m0_readdatavalid}, {31'd0, ret_vld && ret_owner == 0});
      chk("rdv1", {31'd0, m1_readdatavalid}, {31'd0, ret_vld && ret_owner == 1});
      if (ret_vld) begin
        chk(ret_owner == 0 ? "rdata0" : "rdata1",
            ret_owner == 0 ? m0_readdata : m1_readdata, ret_data);
        chk(ret_owner == 0 ? "idle_rdata1" : "idle_rdata0",
            ret_owner == 0 ? m1_readdata : m0_readdata, 32'd0);
      end
      if (g >= 0) begin
        chk("mem_addr", {20'd0, mem_address}, {20'd0, p[g].addr});
        chk("mem_wr", {31'd0, mem_write}, {31'd0, p[g].wr});
        if (p[g].wr) begin
          chk("mem_be", {28'd0, mem_byteenable}, {28'd0, p[g].be});
          chk("mem_wdata", mem_writedata, p[g].data);
          for (int b = 0; b < 4; b++)
            if (p[g].be[b]) shadow[p[g].addr][8*b +: 8] = p[g].data[8*b +: 8];
        end else begin
          nret_vld = 1'b1; nret_owner = g; nret_data = shadow[p[g].addr];
        end
        prev_gnt = g;
        p[g].vld = 1'b0;
      end
    end
    ret_vld = nret_vld; ret_owner = nret_owner; ret_data = nret_data;
    @(posedge clk);
    #1;
  endtask

  int c0, c1;

  initial begin
    for (int i = 0; i < 4096; i++) begin ram[i] = '0; shadow[i] = '0; end
    ram_q = '0;
    for (int m = 0; m < 2; m++) begin
      p[m].vld = 0; p[m].rd = 0; p[m].wr = 0; p[m].addr = '0; p[m].be = '0; p[m].data = '0;
      cnt_rdv[m] = 0; last_rd[m] = '0;
    end
    prev_gnt = 1; ret_vld = 0; ret_owner = 0; ret_data = '0;

    step(1); step(1); step(0);

    // continuous read contention for 8 cycles straight out of reset
    c0 = cnt_rdv[0]; c1 = cnt_rdv[1];
    for (int i = 0; i < 8; i++) begin
      for (int m = 0; m < 2; m++)
        if (!p[m].vld) issue(m, 1, 0, 12'h100 + 12'(m), 4'hF, 32'd0);
      step(0);
    end
    p[0].vld = 0; p[1].vld = 0;
    step(0);
`ifdef ONCHIP_ARB_RR_EN
    chk("cont_rdv0", cnt_rdv[0] - c0, 32'd4);
    chk("cont_rdv1", cnt_rdv[1] - c1, 32'd4);
`else
    chk("cont_rdv0", cnt_rdv[0] - c0, 32'd8);
    chk("cont_rdv1", cnt_rdv[1] - c1, 32'd0);
`endif

    // m0 write then read back
    issue(0, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF); step(0);
    issue(0, 1, 0, 12'h010, 4'hF, 32'd0);        step(0);
    step(0);
    chk("t1_rdata", last_rd[0], 32'hDEADBEEF);

    // m1 byte-lane merge at the top address
    issue(1, 0, 1, 12'hFFF, 4'hF, 32'h11223344); step(0);
    issue(1, 0, 1, 12'hFFF, 4'h8, 32'hAA000000); step(0);
    issue(1, 1, 0, 12'hFFF, 4'hF, 32'd0);        step(0);
    step(0);
    chk("be_rdata", last_rd[1], 32'hAA223344);

    // read+write together is a write with no return
    c0 = cnt_rdv[0];
    issue(0, 1, 1, 12'h020, 4'hF, 32'h5A5A5A5A); step(0);
    step(0);
    chk("rw_no_rdv", cnt_rdv[0] - c0, 32'd0);
    issue(0, 1, 0, 12'h020, 4'hF, 32'd0); step(0);
    step(0);
    chk("rw_rdata", last_rd[0], 32'h5A5A5A5A);

    // random traffic from both masters
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++)
        if (!p[m].vld && $urandom_range(0, 9) < 6) begin
          case ($urandom_range(0, 3))
            0, 3: issue(m, 1, 0, 12'($urandom_range(0, 15)), 4'hF, 32'd0);
            1:    issue(m, 0, 1, 12'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), $urandom);
            default: issue(m, 1, 1, 12'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), $urandom);
          endcase
        end
      step(0);
    end
    p[0].vld = 0; p[1].vld = 0;
    step(0);

    // reset in the cycle after a read accept kills the return
    c0 = cnt_rdv[0];
    issue(0, 1, 0, 12'h010, 4'hF, 32'd0); step(0);
    step(1);
    step(0); step(0);
    chk("rst_drop_rdv", cnt_rdv[0] - c0, 32'd0);
    issue(0, 1, 0, 12'h011, 4'hF, 32'd0);
    issue(1, 1, 0, 12'h012, 4'hF, 32'd0);
    chk("post_rst_gnt", {31'd0, p[0].vld}, 32'd1);
    step(0);
    chk("post_rst_m1_held", {31'd0, p[1].vld}, 32'd1);
    step(0); step(0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
